// File: rtl/mxint8_ctrl_pkg.sv
// Shared types and sizing for the MXINT8 block-sum controller.
// Width macros default here when no project include has defined them.
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif
`ifndef SCALE_WIDTH
`define SCALE_WIDTH 8
`endif
`ifndef MXINT8_ELEMENT_WIDTH
`define MXINT8_ELEMENT_WIDTH 8
`endif
`ifndef FLOAT32_WIDTH
`define FLOAT32_WIDTH 32
`endif

package mxint8_ctrl_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EVAL = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int BLOCK_SIZE = `BLOCK_SIZE;

    // Number of input beats needed to assemble one block.
    function automatic int calc_beats(input int lanes);
        return BLOCK_SIZE / lanes;
    endfunction

endpackage

// File: rtl/mxint8_sum.sv
// Combinational MXINT8 block sum: adds BLOCK_SIZE signed 1.6 fixed-point elements,
// applies the shared E8M0 scale and returns an exact float32 (no rounding needed).
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif
`ifndef SCALE_WIDTH
`define SCALE_WIDTH 8
`endif
`ifndef MXINT8_ELEMENT_WIDTH
`define MXINT8_ELEMENT_WIDTH 8
`endif
`ifndef FLOAT32_WIDTH
`define FLOAT32_WIDTH 32
`endif

module mxint8_sum (
    input  logic [`SCALE_WIDTH-1:0]                      i_scale,
    input  logic [`BLOCK_SIZE*`MXINT8_ELEMENT_WIDTH-1:0] i_elements,
    output logic [`FLOAT32_WIDTH-1:0]                    o_float32,
    output logic                                         o_overflow,
    output logic                                         o_is_unused
);

    localparam int EW        = `MXINT8_ELEMENT_WIDTH;
    localparam int FRAC_BITS = EW - 2;
    localparam int SUM_W     = EW + $clog2(`BLOCK_SIZE);
    localparam int MSB_W     = $clog2(SUM_W);

    logic signed [SUM_W-1:0] elem_ext [`BLOCK_SIZE];
    logic signed [SUM_W-1:0] sum;
    logic        [SUM_W-1:0] mag;
    logic        [MSB_W-1:0] msb;
    logic     [SUM_W+22:0]   wide;
    logic                    sign;
    int                      biased;

    genvar gi;
    generate
        for (gi = 0; gi < `BLOCK_SIZE; gi++) begin : g_ext
            assign elem_ext[gi] = {{(SUM_W-EW){i_elements[gi*EW+EW-1]}}, i_elements[gi*EW +: EW]};
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int i = 0; i < `BLOCK_SIZE; i++) begin
            sum = sum + elem_ext[i];
        end
    end

    assign sign = sum[SUM_W-1];
    assign mag  = sign ? SUM_W'(-sum) : SUM_W'(sum);

    always_comb begin
        msb = '0;
        for (int i = 0; i < SUM_W; i++) begin
            if (mag[i]) begin
                msb = MSB_W'(i);
            end
        end
    end

    // value = mag * 2^(msb) normalised; biased exponent = msb + scale - FRAC_BITS
    assign biased = int'(msb) + int'(i_scale) - FRAC_BITS;
    assign wide   = {{23{1'b0}}, mag} << (23 - int'(msb));

    always_comb begin
        o_float32   = '0;
        o_overflow  = 1'b0;
        o_is_unused = 1'b0;
        if (i_scale == '1) begin
            // E8M0 NaN scale marks the block as unused
            o_float32   = 32'h7FC0_0000;
            o_is_unused = 1'b1;
        end else if (mag == '0) begin
            o_float32 = '0;
        end else if (biased >= 255) begin
            o_float32  = {sign, 8'hFF, 23'd0};
            o_overflow = 1'b1;
        end else if (biased <= 0) begin
            o_float32 = {sign, 31'd0};
        end else begin
            o_float32 = {sign, biased[7:0], wide[22:0]};
        end
    end

endmodule

// File: rtl/mxint8_sum_ctrl.sv
// Beat-assembling controller around mxint8_sum: FILL -> EVAL -> OUT handshake FSM.
// Optional result statistics are built when MXINT8_SUM_CTRL_STATS_EN is defined.
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif
`ifndef SCALE_WIDTH
`define SCALE_WIDTH 8
`endif
`ifndef MXINT8_ELEMENT_WIDTH
`define MXINT8_ELEMENT_WIDTH 8
`endif
`ifndef FLOAT32_WIDTH
`define FLOAT32_WIDTH 32
`endif

module mxint8_sum_ctrl
    import mxint8_ctrl_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_valid,
    output logic                                  o_ready,
    input  logic [`SCALE_WIDTH-1:0]               i_scale,
    input  logic [LANES*`MXINT8_ELEMENT_WIDTH-1:0] i_elements,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic [`FLOAT32_WIDTH-1:0]             o_float32,
    output logic                                  o_overflow,
    output logic                                  o_is_unused,
    output logic                                  o_busy
`ifdef MXINT8_SUM_CTRL_STATS_EN
    ,
    input  logic                                  i_stats_clr,
    output logic [15:0]                           o_blk_cnt,
    output logic [15:0]                           o_ovf_cnt
`endif
);

    localparam int EW    = `MXINT8_ELEMENT_WIDTH;
    localparam int BEATS = calc_beats(LANES);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t                       state_reg, state_next;
    logic [CNT_W-1:0]             cnt_reg, cnt_next;
    logic [`SCALE_WIDTH-1:0]      scale_reg;
    logic                         accept;
    logic                         last_beat;
    logic [`BLOCK_SIZE*EW-1:0]    block_flat;
    logic [`FLOAT32_WIDTH-1:0]    sum_float;
    logic                         sum_overflow;
    logic                         sum_unused;
    logic [`FLOAT32_WIDTH-1:0]    float_reg;
    logic                         overflow_reg;
    logic                         unused_reg;

    assign last_beat = (cnt_reg == CNT_W'(BEATS - 1));
    assign accept    = i_valid && o_ready;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        case (state_reg)
            FILL: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    if (last_beat) begin
                        cnt_next   = '0;
                        state_next = EVAL;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            EVAL: state_next = OUT;
            OUT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= FILL;
            cnt_reg   <= '0;
            scale_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept && cnt_reg == '0) begin
                scale_reg <= i_scale;
            end
        end
    end

    // One small memory per lane, indexed by beat; contents survive reset by design.
    genvar gi, gj;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [EW-1:0] lane_mem [BEATS];

            always_ff @(posedge clk) begin
                if (accept) begin
                    lane_mem[cnt_reg] <= i_elements[gi*EW +: EW];
                end
            end

            for (gj = 0; gj < BEATS; gj++) begin : g_beat
                assign block_flat[(gj*LANES + gi)*EW +: EW] = lane_mem[gj];
            end
        end
    endgenerate

    mxint8_sum u_sum (
        .i_scale     (scale_reg),
        .i_elements  (block_flat),
        .o_float32   (sum_float),
        .o_overflow  (sum_overflow),
        .o_is_unused (sum_unused)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            float_reg    <= '0;
            overflow_reg <= 1'b0;
            unused_reg   <= 1'b0;
        end else if (state_reg == EVAL) begin
            float_reg    <= sum_float;
            overflow_reg <= sum_overflow;
            unused_reg   <= sum_unused;
        end
    end

    assign o_float32   = float_reg;
    assign o_overflow  = overflow_reg;
    assign o_is_unused = unused_reg;
    assign o_busy      = (state_reg != FILL) || (cnt_reg != '0);

`ifdef MXINT8_SUM_CTRL_STATS_EN
    logic [15:0] blk_cnt_reg;
    logic [15:0] ovf_cnt_reg;
    logic        handoff;

    assign handoff = o_valid && i_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || i_stats_clr) begin
            blk_cnt_reg <= '0;
            ovf_cnt_reg <= '0;
        end else if (handoff) begin
            if (blk_cnt_reg != '1) begin
                blk_cnt_reg <= blk_cnt_reg + 16'd1;
            end
            if (overflow_reg && ovf_cnt_reg != '1) begin
                ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
            end
        end
    end

    assign o_blk_cnt = blk_cnt_reg;
    assign o_ovf_cnt = ovf_cnt_reg;
`endif

endmodule

// File: tb/tb_mxint8_sum_ctrl.sv
// Directed bench for mxint8_sum_ctrl with LANES=4 and a 32-element block.
// Counter checks are included when MXINT8_SUM_CTRL_STATS_EN is defined.
module tb_mxint8_sum_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [7:0]  i_scale = 8'd0;
    logic [31:0] i_elements = 32'd0;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_float32;
    logic        o_overflow;
    logic        o_is_unused;
    logic        o_busy;
`ifdef MXINT8_SUM_CTRL_STATS_EN
    logic        i_stats_clr = 1'b0;
    logic [15:0] o_blk_cnt;
    logic [15:0] o_ovf_cnt;
`endif

    int total = 0;
    int bad   = 0;

    mxint8_sum_ctrl #(.LANES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_scale     (i_scale),
        .i_elements  (i_elements),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_float32   (o_float32),
        .o_overflow  (o_overflow),
        .o_is_unused (o_is_unused),
        .o_busy      (o_busy)
`ifdef MXINT8_SUM_CTRL_STATS_EN
        ,
        .i_stats_clr (i_stats_clr),
        .o_blk_cnt   (o_blk_cnt),
        .o_ovf_cnt   (o_ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] scale, input logic [7:0] elem, input int gap);
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL beat_ready: o_ready=%b required 1", o_ready);
        end
        i_valid    = 1'b1;
        i_scale    = scale;
        i_elements = {4{elem}};
        tick();
        i_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // Eight beats; returns #1 after the edge that accepted the last beat.
    task automatic send_block(input logic [7:0] scale_first, input logic [7:0] scale_rest,
                              input logic [7:0] elem);
        send_beat(scale_first, elem, 0);
        for (int b = 1; b < 8; b++) send_beat(scale_rest, elem, 0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (o_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (o_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: o_valid=%b required 1 within 20 cycles", name, o_valid);
        end
    endtask

    task automatic handshake();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({o_valid, o_overflow, o_is_unused, o_busy} !== 4'b0000 || o_float32 !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b ovf=%b unused=%b busy=%b float=%h required 0",
                     o_valid, o_overflow, o_is_unused, o_busy, o_float32);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: o_ready=%b required 1", o_ready);
        end
        $display("reset: ready=%b busy=%b", o_ready, o_busy);
    endtask

    task automatic test_back_to_back();
        send_block(8'd127, 8'd127, 8'h40);
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_eval: valid=%b ready=%b required 0 0", o_valid, o_ready);
        end
        tick();
        total++;
        if (o_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_latency: o_valid=%b required 1", o_valid);
        end
        total++;
        if (o_float32 !== 32'h4200_0000 || o_overflow !== 1'b0 || o_is_unused !== 1'b0) begin
            bad++;
            $display("FAIL b2b_result: float=%h ovf=%b unused=%b required 42000000 0 0",
                     o_float32, o_overflow, o_is_unused);
        end
        $display("back_to_back: float=%h ovf=%b", o_float32, o_overflow);
        handshake();
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_release: valid=%b ready=%b busy=%b required 0 1 0",
                     o_valid, o_ready, o_busy);
        end
    endtask

    task automatic test_gaps();
        for (int b = 0; b < 7; b++) send_beat(8'd127, 8'h00, 3);
        total++;
        if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL gaps_partial: valid=%b busy=%b required 0 1", o_valid, o_busy);
        end
        send_beat(8'd127, 8'h00, 0);
        wait_valid("gaps");
        total++;
        if (o_float32 !== 32'h0000_0000 || o_overflow !== 1'b0) begin
            bad++;
            $display("FAIL gaps_result: float=%h ovf=%b required 00000000 0", o_float32, o_overflow);
        end
        $display("gaps: float=%h", o_float32);
        handshake();
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL gaps_cnt_zero: busy=%b required 0", o_busy);
        end
    endtask

    task automatic test_hold();
        send_block(8'd127, 8'd127, 8'h40);
        wait_valid("hold");
        i_valid    = 1'b1;
        i_scale    = 8'd127;
        i_elements = {4{8'h40}};
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_float32 !== 32'h4200_0000 ||
                o_overflow !== 1'b0 || o_is_unused !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d: ready=%b valid=%b float=%h ovf=%b required 0 1 42000000 0",
                         c, o_ready, o_valid, o_float32, o_overflow);
            end
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        total++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL hold_after_handshake: ready=%b busy=%b required 1 0", o_ready, o_busy);
        end
        tick();
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL hold_next_first_beat: busy=%b required 1", o_busy);
        end
        for (int b = 1; b < 8; b++) send_beat(8'd127, 8'h40, 0);
        wait_valid("hold_next");
        total++;
        if (o_float32 !== 32'h4200_0000) begin
            bad++;
            $display("FAIL hold_next_result: float=%h required 42000000", o_float32);
        end
        $display("hold: next block float=%h", o_float32);
        handshake();
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 5; b++) send_beat(8'd127, 8'h40, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_float32 !== 32'h0 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_state: valid=%b busy=%b float=%h ready=%b required 0 0 00000000 1",
                     o_valid, o_busy, o_float32, o_ready);
        end
        send_block(8'd127, 8'd127, 8'h40);
        wait_valid("midreset");
        total++;
        if (o_float32 !== 32'h4200_0000) begin
            bad++;
            $display("FAIL midreset_result: float=%h required 42000000", o_float32);
        end
        $display("reset_mid: fresh block float=%h", o_float32);
        handshake();
    endtask

    task automatic test_scale_first_beat();
        send_block(8'd128, 8'd0, 8'h40);
        wait_valid("scale");
        total++;
        if (o_float32 !== 32'h4280_0000) begin
            bad++;
            $display("FAIL scale_first_beat: float=%h required 42800000", o_float32);
        end
        $display("scale_first_beat: float=%h", o_float32);
        handshake();
    endtask

    task automatic test_negative();
        send_block(8'd126, 8'd126, 8'hC0);
        wait_valid("neg");
        total++;
        if (o_float32 !== 32'hC180_0000 || o_overflow !== 1'b0) begin
            bad++;
            $display("FAIL negative: float=%h ovf=%b required c1800000 0", o_float32, o_overflow);
        end
        $display("negative: float=%h", o_float32);
        handshake();
    endtask

    task automatic test_overflow_unused();
        send_block(8'd254, 8'd254, 8'h40);
        wait_valid("ovf");
        total++;
        if (o_float32 !== 32'h7F80_0000 || o_overflow !== 1'b1 || o_is_unused !== 1'b0) begin
            bad++;
            $display("FAIL overflow: float=%h ovf=%b unused=%b required 7f800000 1 0",
                     o_float32, o_overflow, o_is_unused);
        end
        $display("overflow: float=%h ovf=%b", o_float32, o_overflow);
        handshake();
        send_block(8'd255, 8'd255, 8'h40);
        wait_valid("unused");
        total++;
        if (o_float32 !== 32'h7FC0_0000 || o_overflow !== 1'b0 || o_is_unused !== 1'b1) begin
            bad++;
            $display("FAIL unused: float=%h ovf=%b unused=%b required 7fc00000 0 1",
                     o_float32, o_overflow, o_is_unused);
        end
        $display("unused: float=%h unused=%b", o_float32, o_is_unused);
        handshake();
    endtask

`ifdef MXINT8_SUM_CTRL_STATS_EN
    task automatic test_stats();
        i_stats_clr = 1'b1;
        tick();
        i_stats_clr = 1'b0;
        total++;
        if (o_blk_cnt !== 16'd0 || o_ovf_cnt !== 16'd0) begin
            bad++;
            $display("FAIL stats_initial_clear: blk=%0d ovf=%0d required 0 0", o_blk_cnt, o_ovf_cnt);
        end
        send_block(8'd127, 8'd127, 8'h40);
        wait_valid("stats1");
        handshake();
        send_block(8'd254, 8'd254, 8'h40);
        wait_valid("stats2");
        handshake();
        send_block(8'd127, 8'd127, 8'h00);
        wait_valid("stats3");
        handshake();
        total++;
        if (o_blk_cnt !== 16'd3 || o_ovf_cnt !== 16'd1) begin
            bad++;
            $display("FAIL stats_counts: blk=%0d ovf=%0d required 3 1", o_blk_cnt, o_ovf_cnt);
        end
        $display("stats: blk=%0d ovf=%0d", o_blk_cnt, o_ovf_cnt);
        i_stats_clr = 1'b1;
        tick();
        i_stats_clr = 1'b0;
        total++;
        if (o_blk_cnt !== 16'd0 || o_ovf_cnt !== 16'd0) begin
            bad++;
            $display("FAIL stats_clear: blk=%0d ovf=%0d required 0 0", o_blk_cnt, o_ovf_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_hold();
        test_reset_mid();
        test_scale_first_beat();
        test_negative();
        test_overflow_unused();
`ifdef MXINT8_SUM_CTRL_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
